// File: rtl/draw_arbiter.sv
// draw_arbiter: grants one render requester at a time the VGA pixel port and forwards its pixels.
// Optional watchdog when DRAW_ARB_TIMEOUT_EN is defined.
module draw_arbiter #(
  parameter  int SCREEN_X       = 640,
  parameter  int SCREEN_Y       = 480,
  parameter  int N_REQ          = 4,
  parameter  int TIMEOUT_CYCLES = 524288,
  localparam int XW             = $clog2(SCREEN_X) + 1,
  localparam int YW             = $clog2(SCREEN_Y) + 1,
  localparam int IW             = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    done,
  input  logic [N_REQ*XW-1:0] in_x,
  input  logic [N_REQ*YW-1:0] in_y,
  input  logic [N_REQ*3-1:0]  in_col,
  output logic [N_REQ-1:0]    gnt,
  output logic [XW-1:0]       vga_x,
  output logic [YW-1:0]       vga_y,
  output logic [2:0]          vga_col,
  output logic                plot,
  output logic                busy,
  output logic                timeout_err
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACTIVE, S_RELEASE} state_e;

  state_e                   state_q, state_d;
  logic [N_REQ-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]            owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]            rr_win, win;
  logic                     plot_q, plot_d;
  logic [XW-1:0]            vga_x_q, vga_x_d;
  logic [YW-1:0]            vga_y_q, vga_y_d;
  logic [2:0]               vga_col_q, vga_col_d;
  logic [N_REQ-1:0][XW-1:0] x_arr;
  logic [N_REQ-1:0][YW-1:0] y_arr;
  logic [N_REQ-1:0][2:0]    c_arr;
  logic                     wd_expire;
  int                       idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign x_arr[i] = in_x[i*XW +: XW];
    assign y_arr[i] = in_y[i*YW +: YW];
    assign c_arr[i] = in_col[i*3 +: 3];
  end

  // Round-robin over 1..N_REQ-1; descending scan so the slot closest to rr_ptr wins.
  always_comb begin
    rr_win = rr_ptr_q;
    idx    = 0;
    for (int k = N_REQ-2; k >= 0; k--) begin
      idx = ((int'(rr_ptr_q) - 1 + k) % (N_REQ-1)) + 1;
      if (req[idx]) rr_win = IW'(idx);
    end
  end

  assign win = req[0] ? '0 : rr_win;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    plot_d    = 1'b0;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    case (state_q)
      S_IDLE: if (|req) begin
        owner_d      = win;
        gnt_d        = '0;
        gnt_d[win]   = 1'b1;
        state_d      = S_GRANT;
      end
      S_GRANT: state_d = S_ACTIVE;
      S_ACTIVE: if (done[owner_q] || wd_expire) begin
        gnt_d   = '0;
        state_d = S_RELEASE;
      end else begin
        plot_d    = 1'b1;
        vga_x_d   = x_arr[owner_q];
        vga_y_d   = y_arr[owner_q];
        vga_col_d = c_arr[owner_q];
      end
      S_RELEASE: begin
        // The blackscreen requester has its own priority and leaves the rotation alone.
        if (owner_q != '0)
          rr_ptr_d = (owner_q == IW'(N_REQ-1)) ? IW'(1) : owner_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= IW'(1);
      plot_q    <= 1'b0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      plot_q    <= plot_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
    end
  end

`ifdef DRAW_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  // Expires on the TIMEOUT_CYCLES-th ACTIVE cycle, which is then treated as the done cycle.
  assign wd_expire = (state_q == S_ACTIVE) && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_IDLE && |req) begin
      wd_d = '0;
    end else if (state_q == S_ACTIVE && !done[owner_q]) begin
      wd_d = wd_q + WW'(1);
      if (wd_expire) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign plot    = plot_q;
  assign vga_x   = vga_x_q;
  assign vga_y   = vga_y_q;
  assign vga_col = vga_col_q;
  assign busy    = (state_q != S_IDLE);

endmodule
